idma_axis_stream_endpoint: RTL and testbench
============================================

# idma_axis_stream_endpoint

AXI-Stream endpoint that terminates both stream ports of the AXI-Stream iDMA back-end: it is the subordinate for the DMA's stream write port and the manager for the DMA's stream read port. Beats written by the DMA are buffered in an internal FIFO and replayed to the DMA's read port, so the block serves as a loopback sink/source for memory-to-stream-to-memory traffic. It supports cut-through and store-and-forward packet modes, flushing, and status counters.

## Interface
- `Depth`, 16: FIFO depth in beats, ≥2, power of two.
- `StoreAndForward`, 1'b0: when set, output is released per complete packet.
- `axis_req_t`, logic: stream request type; fields `t` (type `axis_t_chan_t`: data, strb, keep, last, id, dest, user) and `tvalid`.
- `axis_t_chan_t`, logic: stream payload type; stored verbatim.
- `axis_rsp_t`, logic: stream response type; field `tready`.
- `CntWidth`, $clog2(Depth+1): derived, do not override.

Ports:
- `clk_i`  in  1  clock; all logic rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous drop of all buffered beats.
- `in_req_i`  in  axis_req_t  stream from the DMA write port.
- `in_rsp_o`  out  axis_rsp_t  tready toward the DMA write port.
- `out_req_o`  out  axis_req_t  stream toward the DMA read port.
- `out_rsp_i`  in  axis_rsp_t  tready from the DMA read port.
- `fill_o`  out  CntWidth  beats currently buffered.
- `pkts_o`  out  CntWidth  complete packets (tlast beats) currently buffered.
- `rx_pkts_o`  out  32  total tlast beats accepted since reset; wraps.
- `tx_pkts_o`  out  32  total tlast beats emitted since reset; wraps.

## Operation
- Storage: circular buffer of `Depth` entries of `axis_t_chan_t`, write pointer, read pointer, occupancy counter `fill`.
- Push: `in_req_i.tvalid && in_rsp_o.tready && !flush_i`. `in_rsp_o.tready = (fill != Depth) && !rst_i`; no full-bypass (a pop in the same cycle does not enable a push while full).
- Pop: `out_req_o.tvalid && out_rsp_i.tready && !flush_i`. `out_req_o.t` = entry at read pointer.
- Simultaneous push and pop: `fill` unchanged; both pointers advance.
- `pkts`: +1 on push of a last beat, −1 on pop of a last beat; both in same cycle → unchanged.
- Output valid:
  - Cut-through (`StoreAndForward=0`): `tvalid = fill != 0`.
  - Store-and-forward: `tvalid = (fill != 0) && (pkts != 0 || fill == Depth)`. Full-with-no-tlast releases beats (cut-through fallback) to prevent deadlock on packets longer than `Depth`.
- Once `tvalid` is high, it stays high and `t` stays stable until the pop (AXI-Stream rule), except on `flush_i` or reset.
- `flush_i`: next cycle `fill=0`, `pkts=0`, pointers equal; push and pop suppressed in the flush cycle; `rx_pkts_o`/`tx_pkts_o` untouched.
- Pointers and counters wrap modulo `Depth` / 2^32.

## Timing
- Reset values: `out_req_o.tvalid=0`, `out_req_o.t='0`, `in_rsp_o.tready=0` while `rst_i` is high, and 1 in the first cycle after release. `fill_o=0`, `pkts_o=0`, `rx_pkts_o=0`, `tx_pkts_o=0`.
- Latency: a beat pushed at edge N is visible on `out_req_o` in cycle N+1 (no combinational in→out path).
- Store-and-forward: the first beat of a packet becomes valid the cycle after its tlast beat is pushed.
- Throughput: 1 beat/cycle sustained when `fill` is between 1 and `Depth−1`.
- `in_rsp_o.tready` depends only on registered state (no dependence on `out_rsp_i`).
- Reset mid-transfer: all buffered beats are lost; outputs take reset values immediately (asynchronous).

## Test plan
- Cut-through with the sink always ready; push 4 beats, data 0x11..0x44, last on 4th → output beats 0x11..0x44 in cycles N+1..N+4, `tx_pkts_o=1`, `fill_o` returns to 0.
- Store-and-forward with a 3-beat packet, 1 beat every other cycle → `out tvalid` stays low until the cycle after beat 3; then 3 beats back-to-back; `pkts_o` goes 1→0.
- Full/backpressure with `Depth=16` and `out tready=0`; push 20 beats → `in tready` drops after 16, `fill_o=16`; raise `out tready` → all 20 beats delivered in order, none lost or duplicated.
- Oversize packet in store-and-forward: 24-beat packet with `Depth=16` → release starts when `fill_o=16`; all 24 beats delivered, last flagged only on beat 24.
- Flush: 5 beats buffered, `flush_i` pulsed 1 cycle → next cycle `fill_o=0`, `pkts_o=0`, `tvalid=0`; `rx_pkts_o` retains its value.
- Reset mid-stream: assert `rst_i` with 7 beats buffered and valid held high → immediately `tvalid=0`, `tready=0`, all counters 0; after release, a new 2-beat packet passes correctly.

Source files
------------

// File: rtl/idma_axis_stream_endpoint.sv
// Loopback AXI-Stream endpoint: beats written by the DMA are buffered in a FIFO and replayed
// to the DMA read port, in cut-through or store-and-forward packet mode, with status counters.
package idma_axis_stream_endpoint_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [3:0]  user;
  } axis_t_chan_t;

  typedef struct packed {
    axis_t_chan_t t;
    logic         tvalid;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

module idma_axis_stream_endpoint #(
  parameter int unsigned Depth           = 16,
  parameter bit          StoreAndForward = 1'b0,
  parameter type         axis_req_t      = idma_axis_stream_endpoint_pkg::axis_req_t,
  parameter type         axis_t_chan_t   = idma_axis_stream_endpoint_pkg::axis_t_chan_t,
  parameter type         axis_rsp_t      = idma_axis_stream_endpoint_pkg::axis_rsp_t,
  parameter int unsigned CntWidth        = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  axis_req_t           in_req_i,
  output axis_rsp_t           in_rsp_o,
  output axis_req_t           out_req_o,
  input  axis_rsp_t           out_rsp_i,
  output logic [CntWidth-1:0] fill_o,
  output logic [CntWidth-1:0] pkts_o,
  output logic [31:0]         rx_pkts_o,
  output logic [31:0]         tx_pkts_o
);

  localparam int unsigned         PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  axis_t_chan_t        mem_q [Depth];
  axis_t_chan_t        head;
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0] fill_q, fill_d, pkts_q, pkts_d;
  logic [31:0]         rx_q, rx_d, tx_q, tx_d;
  logic                in_ready, out_valid;
  logic                push, pop, push_last, pop_last;

  assign head = mem_q[rptr_q];

  // tready looks only at registered occupancy: a pop cannot free a slot for a same-cycle push.
  assign in_ready = (fill_q != FullCnt) && !rst_i;

  // A full buffer with no tlast must drain anyway, or an oversize packet would deadlock.
  assign out_valid = (fill_q != '0) &&
                     (!StoreAndForward || (pkts_q != '0) || (fill_q == FullCnt));

  assign push      = in_req_i.tvalid && in_ready && !flush_i;
  assign pop       = out_valid && out_rsp_i.tready && !flush_i;
  assign push_last = push && in_req_i.t.last;
  assign pop_last  = pop && head.last;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    pkts_d = pkts_q;
    rx_d   = rx_q + 32'(push_last);
    tx_d   = tx_q + 32'(pop_last);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
      pkts_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   fill_d = fill_q + CntWidth'(1);
        2'b01:   fill_d = fill_q - CntWidth'(1);
        default: fill_d = fill_q;
      endcase
      case ({push_last, pop_last})
        2'b10:   pkts_d = pkts_q + CntWidth'(1);
        2'b01:   pkts_d = pkts_q - CntWidth'(1);
        default: pkts_d = pkts_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      pkts_q <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      pkts_q <= pkts_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= in_req_i.t;
  end

  always_comb begin
    out_req_o        = '0;
    out_req_o.tvalid = out_valid;
    if (out_valid) out_req_o.t = head;
    in_rsp_o         = '0;
    in_rsp_o.tready  = in_ready;
  end

  assign fill_o    = fill_q;
  assign pkts_o    = pkts_q;
  assign rx_pkts_o = rx_q;
  assign tx_pkts_o = tx_q;

endmodule

// File: tb/tb_idma_axis_stream_endpoint.sv
// Scoreboard bench for idma_axis_stream_endpoint: one cut-through and one store-and-forward
// instance, stimulus steered to whichever the current scenario selects.
module tb_idma_axis_stream_endpoint;
  import idma_axis_stream_endpoint_pkg::*;

  typedef struct {
    axis_t_chan_t t;
    int           exp_edge;
  } sb_ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic sel = 1'b0;
  axis_req_t drv_req = '0;
  logic drv_ready = 1'b0;

  axis_req_t in_req_ct, in_req_saf, out_req_ct, out_req_saf;
  axis_rsp_t in_rsp_ct, in_rsp_saf, out_rsp_ct, out_rsp_saf;
  logic [4:0] fill_ct, fill_saf, pkts_ct, pkts_saf;
  logic [31:0] rx_ct, rx_saf, tx_ct, tx_saf;

  logic o_valid, o_in_ready;
  axis_t_chan_t o_t;
  logic [4:0] o_fill, o_pkts;
  logic [31:0] o_rx, o_tx;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int last_acc = 0;
  sb_ent_t sb[$];
  sb_ent_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    in_req_ct = '0;
    in_req_saf = '0;
    out_rsp_ct = '0;
    out_rsp_saf = '0;
    if (sel) begin
      in_req_saf = drv_req;
      out_rsp_saf.tready = drv_ready;
      o_valid = out_req_saf.tvalid;
      o_t = out_req_saf.t;
      o_in_ready = in_rsp_saf.tready;
      o_fill = fill_saf;
      o_pkts = pkts_saf;
      o_rx = rx_saf;
      o_tx = tx_saf;
    end else begin
      in_req_ct = drv_req;
      out_rsp_ct.tready = drv_ready;
      o_valid = out_req_ct.tvalid;
      o_t = out_req_ct.t;
      o_in_ready = in_rsp_ct.tready;
      o_fill = fill_ct;
      o_pkts = pkts_ct;
      o_rx = rx_ct;
      o_tx = tx_ct;
    end
  end

  idma_axis_stream_endpoint #(
    .Depth(16), .StoreAndForward(1'b0),
    .axis_req_t(axis_req_t), .axis_t_chan_t(axis_t_chan_t), .axis_rsp_t(axis_rsp_t)
  ) u_ct (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_req_i(in_req_ct), .in_rsp_o(in_rsp_ct),
    .out_req_o(out_req_ct), .out_rsp_i(out_rsp_ct),
    .fill_o(fill_ct), .pkts_o(pkts_ct), .rx_pkts_o(rx_ct), .tx_pkts_o(tx_ct)
  );

  idma_axis_stream_endpoint #(
    .Depth(16), .StoreAndForward(1'b1),
    .axis_req_t(axis_req_t), .axis_t_chan_t(axis_t_chan_t), .axis_rsp_t(axis_rsp_t)
  ) u_saf (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_req_i(in_req_saf), .in_rsp_o(in_rsp_saf),
    .out_req_o(out_req_saf), .out_rsp_i(out_rsp_saf),
    .fill_o(fill_saf), .pkts_o(pkts_saf), .rx_pkts_o(rx_saf), .tx_pkts_o(tx_saf)
  );

  // Output monitor: every handshake pops the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && !flush && o_valid && drv_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got data=%h, expected no beat", o_t.data);
      end else begin
        mon_e = sb.pop_front();
        pop_cnt++;
        if (o_t !== mon_e.t) begin
          n_fail++;
          $display("FAIL out_beat: got data=%h last=%b user=%h, expected data=%h last=%b user=%h",
                   o_t.data, o_t.last, o_t.user, mon_e.t.data, mon_e.t.last, mon_e.t.user);
        end
        if (mon_e.exp_edge >= 0) begin
          n_tests++;
          if (cyc + 1 != mon_e.exp_edge) begin
            n_fail++;
            $display("FAIL out_timing: data=%h popped at edge %0d, expected edge %0d",
                     o_t.data, cyc + 1, mon_e.exp_edge);
          end
        end
      end
    end
  end

  // Drive one beat, hold it until accepted, record it in the scoreboard.
  task automatic send_beat(input logic [31:0] d, input logic l, input int exp_off);
    sb_ent_t ent;
    int k;
    drv_req = '0;
    drv_req.tvalid = 1'b1;
    drv_req.t.data = d;
    drv_req.t.last = l;
    drv_req.t.strb = 4'hf;
    drv_req.t.keep = 4'hf;
    drv_req.t.user = d[3:0];
    drv_req.t.id = d[7:4];
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_in_ready && k < 200);
    if (!o_in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat %h not accepted, got tready=0 expected 1", d);
    end else begin
      ent.t = drv_req.t;
      ent.exp_edge = (exp_off >= 0) ? cyc + 1 + exp_off : -1;
      sb.push_back(ent);
      last_acc = cyc + 1;
    end
    @(posedge clk);
    #1;
    drv_req.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b expected 0", o_valid); end
    n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b expected 0", o_in_ready); end
    n_tests++; if (o_t !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h expected 0", o_t.data); end
    n_tests++; if (o_fill !== 5'd0 || o_pkts !== 5'd0) begin
      n_fail++; $display("FAIL rst_fill_pkts: got %0d/%0d expected 0/0", o_fill, o_pkts); end
    n_tests++; if (o_rx !== 32'd0 || o_tx !== 32'd0) begin
      n_fail++; $display("FAIL rst_rx_tx: got %0d/%0d expected 0/0", o_rx, o_tx); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready: got %b expected 1", o_in_ready); end
  endtask

  task automatic test_cut_through();
    int p0;
    sel = 1'b0;
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    p0 = pop_cnt;
    for (int i = 1; i <= 4; i++) send_beat(32'h11 * i, i == 4, 1);
    wait_drain();
    n_tests++; if (pop_cnt - p0 != 4) begin n_fail++; $display("FAIL ct_count: got %0d expected 4", pop_cnt - p0); end
    n_tests++; if (o_tx !== 32'd1) begin n_fail++; $display("FAIL ct_tx_pkts: got %0d expected 1", o_tx); end
    n_tests++; if (o_fill !== 5'd0) begin n_fail++; $display("FAIL ct_fill: got %0d expected 0", o_fill); end
  endtask

  task automatic test_store_forward();
    int acc3;
    sel = 1'b1;
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      send_beat(32'hA0 + i, i == 2, -1);
      if (i < 2) begin
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL saf_hold_beat%0d: got tvalid=%b expected 0", i, o_valid); end
        @(posedge clk);
        #1;
      end
    end
    acc3 = last_acc;
    for (int i = 0; i < sb.size(); i++) sb[i].exp_edge = acc3 + 1 + i;
    @(negedge clk);
    n_tests++; if (o_pkts !== 5'd1 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL saf_release: got pkts=%0d tvalid=%b expected 1/1", o_pkts, o_valid); end
    wait_drain();
    n_tests++; if (o_pkts !== 5'd0) begin n_fail++; $display("FAIL saf_pkts_end: got %0d expected 0", o_pkts); end
  endtask

  task automatic test_full_backpressure();
    int p0;
    sel = 1'b0;
    drv_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 16; i++) send_beat(32'h1000 + i, i == 19, -1);
    @(negedge clk);
    n_tests++; if (o_fill !== 5'd16) begin n_fail++; $display("FAIL full_fill: got %0d expected 16", o_fill); end
    fork
      for (int i = 16; i < 20; i++) send_beat(32'h1000 + i, i == 19, -1);
      begin
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_tready: got %b expected 0", o_in_ready); end
        end
        @(posedge clk);
        #1;
        drv_ready = 1'b1;
      end
    join
    wait_drain();
    n_tests++; if (pop_cnt - p0 != 20) begin n_fail++; $display("FAIL full_count: got %0d expected 20", pop_cnt - p0); end
    n_tests++; if (o_fill !== 5'd0) begin n_fail++; $display("FAIL full_fill_end: got %0d expected 0", o_fill); end
  endtask

  task automatic test_oversize();
    int p0;
    logic [31:0] tx0;
    sel = 1'b1;
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    p0 = pop_cnt;
    tx0 = o_tx;
    fork
      for (int i = 0; i < 24; i++) send_beat(32'h2000 + i, i == 23, -1);
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!o_valid && k < 100);
        n_tests++; if (o_fill !== 5'd16 || o_valid !== 1'b1) begin
          n_fail++; $display("FAIL ovs_release_fill: got fill=%0d tvalid=%b expected 16/1", o_fill, o_valid); end
      end
    join
    wait_drain();
    n_tests++; if (pop_cnt - p0 != 24) begin n_fail++; $display("FAIL ovs_count: got %0d expected 24", pop_cnt - p0); end
    n_tests++; if (o_tx - tx0 !== 32'd1) begin n_fail++; $display("FAIL ovs_tx_pkts: got %0d expected 1", o_tx - tx0); end
  endtask

  task automatic test_flush();
    logic [31:0] rx0, tx0;
    sel = 1'b0;
    drv_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'h3000 + i, i == 4, -1);
    @(negedge clk);
    n_tests++; if (o_fill !== 5'd5 || o_pkts !== 5'd1) begin
      n_fail++; $display("FAIL flush_pre: got fill=%0d pkts=%0d expected 5/1", o_fill, o_pkts); end
    rx0 = o_rx;
    tx0 = o_tx;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    n_tests++; if (o_fill !== 5'd0 || o_pkts !== 5'd0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got fill=%0d pkts=%0d tvalid=%b expected 0/0/0", o_fill, o_pkts, o_valid); end
    n_tests++; if (o_rx !== rx0 || o_tx !== tx0) begin
      n_fail++; $display("FAIL flush_counters: got rx=%0d tx=%0d expected %0d/%0d", o_rx, o_tx, rx0, tx0); end
  endtask

  task automatic test_reset_midstream();
    sel = 1'b0;
    drv_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(32'h4000 + i, i == 6, -1);
    drv_req.tvalid = 1'b1;
    drv_req.t.data = 32'h4007;
    #3;
    rst = 1'b1;
    #1;
    n_tests++; if (o_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mrst_handshake: got tvalid=%b tready=%b expected 0/0", o_valid, o_in_ready); end
    n_tests++; if (o_fill !== 5'd0 || o_pkts !== 5'd0 || o_rx !== 32'd0 || o_tx !== 32'd0) begin
      n_fail++; $display("FAIL mrst_counters: got fill=%0d pkts=%0d rx=%0d tx=%0d expected all 0",
                         o_fill, o_pkts, o_rx, o_tx); end
    sb.delete();
    drv_req.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv_ready = 1'b1;
    send_beat(32'h5001, 1'b0, 1);
    send_beat(32'h5002, 1'b1, 1);
    wait_drain();
    n_tests++; if (o_rx !== 32'd1 || o_tx !== 32'd1 || o_fill !== 5'd0) begin
      n_fail++; $display("FAIL mrst_after: got rx=%0d tx=%0d fill=%0d expected 1/1/0", o_rx, o_tx, o_fill); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cut_through();
    test_store_forward();
    test_full_backpressure();
    test_oversize();
    test_flush();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
